// File: rtl/max7219_framebuffer_pkg.sv
// Shared MAX7219 framebuffer types: packet header/register codes, write ops, FSM states.
// Optional back-buffer readback port is enabled by defining MAX7219_FB_READBACK_EN.
package max7219_types;

  localparam logic [3:0] HDR        = 4'h0;
  localparam logic [3:0] REG_DIGIT0 = 4'h1;

  typedef enum logic [1:0] {
    OP_SET    = 2'd0,
    OP_CLR    = 2'd1,
    OP_TOGGLE = 2'd2,
    OP_BYTE   = 2'd3
  } fb_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_COPY  = 2'd2
  } fb_state_e;

  typedef logic [7:0] fb_row_t;

endpackage

// File: rtl/max7219_fb_row_packer.sv
// Packs one digit row of every device into a {HDR, REG, DATA} packet stream.
// Device 0 occupies the least significant packet, i.e. the last bits shifted out.
module max7219_fb_row_packer
  import max7219_types::*;
#(
  parameter int NUM_DEVICES  = 20,
  parameter int PACKET_WIDTH = 16,
  parameter int STREAM_WIDTH = PACKET_WIDTH * NUM_DEVICES,
  parameter int ROW          = 0
) (
  input  fb_row_t [NUM_DEVICES-1:0] row_bytes,
  output logic    [STREAM_WIDTH-1:0] stream
);

  localparam logic [3:0] ROW_REG = REG_DIGIT0 + 4'(ROW);

  always_comb begin
    stream = '0;
    for (int d = 0; d < NUM_DEVICES; d++) begin
      stream[PACKET_WIDTH*d +: 16] = {HDR, ROW_REG, row_bytes[d]};
    end
  end

endmodule

// File: rtl/max7219_framebuffer.sv
// Double-buffered MAX7219 chain framebuffer: pixel/byte writes into a back buffer,
// commit copies to the front buffer which drives 8 row packet streams. MAX7219_FB_READBACK_EN adds a read port.
module max7219_framebuffer
  import max7219_types::*;
#(
  parameter int NUM_DEVICES  = 20,
  parameter int PACKET_WIDTH = 16,
  parameter int STREAM_WIDTH = PACKET_WIDTH * NUM_DEVICES,
  parameter int X_WIDTH      = $clog2(8 * NUM_DEVICES)
) (
  input  logic                           i_Clk,
  input  logic                           i_Rst_n,
  input  logic                           i_Wr_Valid,
  output logic                           o_Wr_Ready,
  input  fb_op_e                         i_Wr_Op,
  input  logic [X_WIDTH-1:0]             i_Wr_X,
  input  logic [2:0]                     i_Wr_Y,
  input  fb_row_t                        i_Wr_Byte,
  output logic                           o_Wr_Err,
  input  logic                           i_Clear,
  input  logic                           i_Clear_Fill,
  input  logic                           i_Commit,
  output logic                           o_Frame_Done,
  output logic [0:7][STREAM_WIDTH-1:0]   o_MAX7219_DataStream,
`ifdef MAX7219_FB_READBACK_EN
  input  logic                           i_Rd_En,
  input  logic [X_WIDTH-1:0]             i_Rd_X,
  input  logic [2:0]                     i_Rd_Y,
  output logic                           o_Rd_Pixel,
  output logic                           o_Rd_Valid,
`endif
  output fb_state_e                      o_Dbg_State
);

  // Write handshake: a write is taken on any rising edge where i_Wr_Valid and
  // o_Wr_Ready are both high; o_Wr_Ready depends only on state, i_Clear and i_Commit.

  localparam int DEV_W    = X_WIDTH - 3;
  localparam int NUM_COLS = 8 * NUM_DEVICES;

  fb_state_e                          state, state_nxt;
  logic [2:0]                         clr_row;
  logic                               clr_fill;
  logic                               clear_active, copy_active;
  logic                               wr_fire, wr_in_range;
  logic [DEV_W-1:0]                   wr_dev;
  logic [2:0]                         wr_bit;
  fb_row_t [0:7][NUM_DEVICES-1:0]     back_buf, front_buf;

  // FSM: state register
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // FSM: next state; clear beats commit, both ignored outside idle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (i_Clear)       state_nxt = ST_CLEAR;
        else if (i_Commit) state_nxt = ST_COPY;
      end
      ST_CLEAR: if (clr_row == 3'd7) state_nxt = ST_IDLE;
      ST_COPY:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_Wr_Ready   = (state == ST_IDLE) & ~i_Clear & ~i_Commit;
    clear_active = (state == ST_CLEAR);
    copy_active  = (state == ST_COPY);
  end

  assign o_Dbg_State = state;
  assign wr_fire     = i_Wr_Valid & o_Wr_Ready;
  assign wr_dev      = i_Wr_X[X_WIDTH-1:3];
  assign wr_bit      = ~i_Wr_X[2:0];
  assign wr_in_range = 32'(i_Wr_X) < 32'(NUM_COLS);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      clr_row  <= '0;
      clr_fill <= 1'b0;
    end else if (state == ST_IDLE && i_Clear) begin
      clr_row  <= '0;
      clr_fill <= i_Clear_Fill;
    end else if (clear_active) begin
      clr_row  <= clr_row + 3'd1;
    end
  end

  // Back buffer: clear sweeps one row per cycle; writes only land while idle
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      back_buf <= '0;
    end else if (clear_active) begin
      back_buf[clr_row] <= {NUM_DEVICES{{8{clr_fill}}}};
    end else if (wr_fire && wr_in_range) begin
      for (int d = 0; d < NUM_DEVICES; d++) begin
        if (wr_dev == DEV_W'(d)) begin
          case (i_Wr_Op)
            OP_SET:    back_buf[i_Wr_Y][d][wr_bit] <= 1'b1;
            OP_CLR:    back_buf[i_Wr_Y][d][wr_bit] <= 1'b0;
            OP_TOGGLE: back_buf[i_Wr_Y][d][wr_bit] <= ~back_buf[i_Wr_Y][d][wr_bit];
            OP_BYTE:   back_buf[i_Wr_Y][d]         <= i_Wr_Byte;
            default:   back_buf[i_Wr_Y][d]         <= back_buf[i_Wr_Y][d];
          endcase
        end
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      front_buf    <= '0;
      o_Frame_Done <= 1'b0;
      o_Wr_Err     <= 1'b0;
    end else begin
      if (copy_active) front_buf <= back_buf;
      o_Frame_Done <= copy_active;
      o_Wr_Err     <= wr_fire & ~wr_in_range;
    end
  end

  // Streams are pure wiring of front-buffer flops plus constant header/register fields
  for (genvar r = 0; r < 8; r++) begin : g_row
    max7219_fb_row_packer #(
      .NUM_DEVICES  (NUM_DEVICES),
      .PACKET_WIDTH (PACKET_WIDTH),
      .STREAM_WIDTH (STREAM_WIDTH),
      .ROW          (r)
    ) u_packer (
      .row_bytes (front_buf[r]),
      .stream    (o_MAX7219_DataStream[r])
    );
  end

`ifdef MAX7219_FB_READBACK_EN
  logic [DEV_W-1:0] rd_dev;
  logic             rd_in_range;

  assign rd_dev      = i_Rd_X[X_WIDTH-1:3];
  assign rd_in_range = 32'(i_Rd_X) < 32'(NUM_COLS);

  // Reads sample back_buf before any same-edge write lands
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Rd_Pixel <= 1'b0;
      o_Rd_Valid <= 1'b0;
    end else begin
      o_Rd_Valid <= i_Rd_En;
      o_Rd_Pixel <= 1'b0;
      if (i_Rd_En && rd_in_range) begin
        for (int d = 0; d < NUM_DEVICES; d++) begin
          if (rd_dev == DEV_W'(d)) o_Rd_Pixel <= back_buf[i_Rd_Y][d][~i_Rd_X[2:0]];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_max7219_framebuffer.sv
// Scoreboard bench for max7219_framebuffer: commits queue expected streams, a monitor checks them on o_Frame_Done.
// Builds with or without MAX7219_FB_READBACK_EN.
module tb_max7219_framebuffer;
  import max7219_types::*;

  localparam int ND = 20;
  localparam int PW = 16;
  localparam int SW = PW * ND;
  localparam int XW = $clog2(8 * ND);
  localparam int W  = 8 * SW;

  typedef logic [0:7][SW-1:0] stream_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          wr_valid = 1'b0;
  logic          wr_ready;
  fb_op_e        wr_op = OP_SET;
  logic [XW-1:0] wr_x = '0;
  logic [2:0]    wr_y = '0;
  logic [7:0]    wr_byte = '0;
  logic          wr_err;
  logic          clear = 1'b0;
  logic          clear_fill = 1'b0;
  logic          commit = 1'b0;
  logic          frame_done;
  stream_t       ds;
  fb_state_e     dbg_state;
`ifdef MAX7219_FB_READBACK_EN
  logic          rd_en = 1'b0;
  logic [XW-1:0] rd_x = '0;
  logic [2:0]    rd_y = '0;
  logic          rd_pixel;
  logic          rd_valid;
`endif

  max7219_framebuffer #(.NUM_DEVICES(ND)) dut (
    .i_Clk                (clk),
    .i_Rst_n              (rst_n),
    .i_Wr_Valid           (wr_valid),
    .o_Wr_Ready           (wr_ready),
    .i_Wr_Op              (wr_op),
    .i_Wr_X               (wr_x),
    .i_Wr_Y               (wr_y),
    .i_Wr_Byte            (wr_byte),
    .o_Wr_Err             (wr_err),
    .i_Clear              (clear),
    .i_Clear_Fill         (clear_fill),
    .i_Commit             (commit),
    .o_Frame_Done         (frame_done),
    .o_MAX7219_DataStream (ds),
`ifdef MAX7219_FB_READBACK_EN
    .i_Rd_En              (rd_en),
    .i_Rd_X               (rd_x),
    .i_Rd_Y               (rd_y),
    .o_Rd_Pixel           (rd_pixel),
    .o_Rd_Valid           (rd_valid),
`endif
    .o_Dbg_State          (dbg_state)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic         err_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [7:0]   m_back [8][ND];
  logic [W-1:0] m_front;
  logic [W-1:0] mon_exp;
  logic         mon_err;

  function automatic logic [W-1:0] model_stream();
    stream_t s;
    s = '0;
    for (int r = 0; r < 8; r++)
      for (int d = 0; d < ND; d++)
        s[r][PW*d +: 16] = {4'h0, 4'(r + 1), m_back[r][d]};
    return s;
  endfunction

  task automatic model_fill(input logic f);
    for (int r = 0; r < 8; r++)
      for (int d = 0; d < ND; d++)
        m_back[r][d] = {8{f}};
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_stream(input string name, input logic [W-1:0] act_flat, input logic [W-1:0] exp_flat);
    stream_t a;
    stream_t e;
    bit      shown;
    a = act_flat;
    e = exp_flat;
    shown = 0;
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      for (int r = 0; r < 8; r++)
        for (int d = 0; d < ND; d++)
          if (!shown && a[r][PW*d +: 16] !== e[r][PW*d +: 16]) begin
            shown = 1;
            $display("FAIL %s: row %0d dev %0d got %h expected %h", name, r, d,
                     a[r][PW*d +: 16], e[r][PW*d +: 16]);
          end
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a frame or an error pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL frame_done: got unexpected pulse, expected none");
        end else begin
          mon_exp = exp_q.pop_front();
          cmp_stream("frame_stream", ds, mon_exp);
        end
      end
      if (wr_err) begin
        if (err_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL wr_err: got unexpected pulse, expected none");
        end else begin
          mon_err = err_q.pop_front();
          check("wr_err", 32'(wr_err), 32'(mon_err));
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_write(input fb_op_e op, input int x, input int y, input logic [7:0] b);
    wr_valid = 1'b1; wr_op = op; wr_x = XW'(x); wr_y = 3'(y); wr_byte = b;
    @(negedge clk);
    check("wr_ready", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    if (x >= 8 * ND) err_q.push_back(1'b1);
    else begin
      case (op)
        OP_SET:    m_back[y][x/8][7 - x%8] = 1'b1;
        OP_CLR:    m_back[y][x/8][7 - x%8] = 1'b0;
        OP_TOGGLE: m_back[y][x/8][7 - x%8] = ~m_back[y][x/8][7 - x%8];
        default:   m_back[y][x/8] = b;
      endcase
    end
  endtask

  task automatic do_commit();
    int n;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    m_front = model_stream();
    exp_q.push_back(m_front);
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL commit_timeout: got no frame_done, expected one within 10 cycles");
      exp_q.delete();
    end
    tick();
  endtask

  // counts cycles with o_Wr_Ready low after the clear-accepting edge
  task automatic wait_clear_done(input string name);
    int low;
    low = 0;
    @(negedge clk);
    while (!wr_ready && low < 20) begin
      low++;
      @(negedge clk);
    end
    check(name, 32'(low), 32'd8);
    tick();
  endtask

  task automatic do_clear(input logic f);
    clear = 1'b1; clear_fill = f;
    @(negedge clk);
    check("ready_during_clear_req", 32'(wr_ready), 32'd0);
    tick();
    clear = 1'b0;
    model_fill(f);
    wait_clear_done("clear_busy_cycles");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_fill(1'b0);
    m_front = model_stream();

    // reset
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", 32'(wr_ready), 32'd1);
    check("reset_err", 32'(wr_err), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    check("reset_row0_pkt0", 32'(ds[0][15:0]), 32'h0100);
    check("reset_row7_pkt19", 32'(ds[7][319:304]), 32'h0800);
    cmp_stream("reset_stream", ds, m_front);
    tick();

    // single pixel, invisible until commit
    do_write(OP_SET, 0, 0, 8'h00);
    @(negedge clk);
    cmp_stream("no_change_before_commit", ds, m_front);
    tick();
    do_commit();
    check("pix_0_0", 32'(ds[0][7:0]), 32'h80);

    // mixed ops across devices and rows
    do_write(OP_SET, 9, 3, 8'h00);
    do_write(OP_SET, 79, 5, 8'h00);
    do_write(OP_CLR, 0, 0, 8'h00);
    do_write(OP_BYTE, 40, 2, 8'h3C);
    do_commit();
    check("dev1_row3", 32'(ds[3][PW*1 +: 16]), 32'h0440);
    check("dev9_row5", 32'(ds[5][PW*9 +: 16]), 32'h0601);
    check("dev5_row2", 32'(ds[2][PW*5 +: 16]), 32'h033C);
    check("pix_0_0_cleared", 32'(ds[0][15:0]), 32'h0100);

    // last device, last row, byte then toggles
    do_write(OP_BYTE, 8*19, 7, 8'hA5);
    do_commit();
    check("last_pkt_byte", 32'(ds[7][319:304]), 32'h08A5);
    do_write(OP_TOGGLE, 8*19 + 1, 7, 8'h00);
    do_commit();
    check("last_pkt_toggle1", 32'(ds[7][319:304]), 32'h08E5);
    do_write(OP_TOGGLE, 8*19 + 1, 7, 8'h00);
    do_commit();
    check("last_pkt_toggle2", 32'(ds[7][319:304]), 32'h08A5);

`ifdef MAX7219_FB_READBACK_EN
    rd_en = 1'b1; rd_x = XW'(8*19); rd_y = 3'd7;
    tick();
    rd_en = 1'b0;
    check("rd_valid", 32'(rd_valid), 32'd1);
    check("rd_pixel", 32'(rd_pixel), 32'd1);
    rd_en = 1'b1; rd_x = XW'(200);
    tick();
    rd_en = 1'b0;
    check("rd_oob_valid", 32'(rd_valid), 32'd1);
    check("rd_oob_pixel", 32'(rd_pixel), 32'd0);
`endif

    // out-of-range writes are dropped with an error pulse
    do_write(OP_SET, 160, 0, 8'h00);
    do_write(OP_BYTE, 255, 4, 8'hFF);
    do_commit();

    // clear + commit + write together: clear only
    clear = 1'b1; clear_fill = 1'b0; commit = 1'b1;
    wr_valid = 1'b1; wr_op = OP_SET; wr_x = XW'(1); wr_y = 3'd1;
    @(negedge clk);
    check("ready_simultaneous", 32'(wr_ready), 32'd0);
    tick();
    clear = 1'b0; commit = 1'b0; wr_valid = 1'b0;
    check("state_after_simultaneous", 32'(dbg_state), 32'(ST_CLEAR));
    model_fill(1'b0);
    wait_clear_done("simul_clear_busy");
    cmp_stream("front_held_after_simul", ds, m_front);
    do_commit();

    // fill with ones
    do_clear(1'b1);
    do_commit();
    check("fill_dev13_row4", 32'(ds[4][PW*13 +: 16]), 32'h05FF);

    // reset in the middle of a clear
    clear = 1'b1; clear_fill = 1'b0;
    tick();
    clear = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_fill(1'b0);
    m_front = model_stream();
    check("midclr_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("midclr_rst_ready", 32'(wr_ready), 32'd1);
    check("midclr_rst_err", 32'(wr_err), 32'd0);
    check("midclr_rst_fd", 32'(frame_done), 32'd0);
    cmp_stream("midclr_rst_stream", ds, m_front);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(wr_ready), 32'd1);
    tick();
    do_write(OP_SET, 100, 6, 8'h00);
    do_commit();
    check("post_rst_pixel", 32'(ds[6][PW*12 +: 16]), 32'h0708);

    repeat (3) tick();
    check("pending_frames", 32'(exp_q.size()), 32'd0);
    check("pending_errors", 32'(err_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
